cpu_step_ctrl: RTL



---
 rtl/cpu_step_ctrl_pkg.sv | 16 +
 rtl/cpu_step_ctrl_edge_pulse.sv | 27 ++
 rtl/cpu_step_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// cpu_step_ctrl_pkg: shared state encodings for the CPU step controller.
//   STATE_W  - width of the state encoding
//   state_t  - S_IDLE=0, S_STEP=1, S_RUN=2, S_BURST=3, S_HALTED=4
package cpu_step_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_STEP   = 3'd1,
        S_RUN    = 3'd2,
        S_BURST  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_step_ctrl_edge_pulse.sv
// edge_pulse: rising-edge detector producing a registered one-cycle event.
//   clk   in  - system clock
//   rst   in  - synchronous active-high reset
//   sig   in  - level input (debounced button)
//   pulse out - one-cycle high after each rising edge of sig
// History clears on reset, so an input already high at reset release
// produces a single event.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= sig;
            pulse <= sig & ~prev;
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns debounced buttons into the MIPS core clock-enable.
// Modes: single-step, free-run, fixed-length burst, and halt from the core.
//   clk, rst      in  - system clock, synchronous active-high reset
//   step_btn      in  - single step request (level)
//   run_btn       in  - run/stop toggle (level)
//   burst_btn     in  - burst of BURST_LEN steps (level)
//   halt_req      in  - core halt request (level)
//   pc, bp_addr   in  - core PC and breakpoint address (breakpoint build only)
//   cpu_en        out - core clock-enable
//   running       out - high in RUN or BURST
//   state_o       out - state encoding
//   step_count    out - wrapping count of issued cpu_en pulses
// Optional feature macro: CPU_STEP_CTRL_BRKPT_EN (PC breakpoint halt).
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int RUN_DIV   = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_btn,
    input  logic             run_btn,
    input  logic             burst_btn,
    input  logic             halt_req,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    output logic             cpu_en,
    output logic             running,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] step_count
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    logic ev_step, ev_run, ev_burst;
    logic halt_hit;
    state_t state;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] remaining;

    edge_pulse u_ep_step  (.clk(clk), .rst(rst), .sig(step_btn),  .pulse(ev_step));
    edge_pulse u_ep_run   (.clk(clk), .rst(rst), .sig(run_btn),   .pulse(ev_run));
    edge_pulse u_ep_burst (.clk(clk), .rst(rst), .sig(burst_btn), .pulse(ev_burst));

`ifdef CPU_STEP_CTRL_BRKPT_EN
    // The matching step has already been issued; halt takes effect after it.
    assign halt_hit = halt_req |
                      (((state == S_RUN) || (state == S_BURST)) && cpu_en && (pc == bp_addr));
`else
    logic unused_brk;
    assign unused_brk = ^{pc, bp_addr};
    assign halt_hit   = halt_req;
`endif

    function automatic logic [DIV_W-1:0] div_next(input logic [DIV_W-1:0] d);
        return (d == DIV_W'(RUN_DIV - 1)) ? '0 : d + 1'b1;
    endfunction

    assign state_o = state;

    // Entering RUN/BURST issues the div==0 pulse immediately, so div is
    // loaded with the phase that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cpu_en     <= 1'b0;
            running    <= 1'b0;
            step_count <= '0;
            div        <= '0;
            remaining  <= '0;
        end else begin
            step_count <= step_count + CNT_W'(cpu_en);
            cpu_en     <= 1'b0;
            if (halt_hit) begin
                state   <= S_HALTED;
                running <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ev_run) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                            cpu_en  <= 1'b1;
                            div     <= div_next('0);
                        end else if (ev_burst) begin
                            state     <= S_BURST;
                            running   <= 1'b1;
                            cpu_en    <= 1'b1;
                            div       <= div_next('0);
                            remaining <= CNT_W'(BURST_LEN - 1);
                        end else if (ev_step) begin
                            state  <= S_STEP;
                            cpu_en <= 1'b1;
                        end
                    end
                    S_STEP: state <= S_IDLE;
                    S_RUN: begin
                        if (ev_run) begin
                            state   <= S_IDLE;
                            running <= 1'b0;
                        end else begin
                            cpu_en <= (div == '0);
                            div    <= div_next(div);
                        end
                    end
                    S_BURST: begin
                        // remaining counts pulses still owed after the one on cpu_en
                        if (ev_run || (remaining == '0)) begin
                            state   <= S_IDLE;
                            running <= 1'b0;
                        end else begin
                            div <= div_next(div);
                            if (div == '0) begin
                                cpu_en    <= 1'b1;
                                remaining <= remaining - 1'b1;
                            end
                        end
                    end
                    S_HALTED: if (ev_run) state <= S_IDLE;
                    default: begin
                        state   <= S_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
